// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared AES decryption widths and InvSubBytes engine state encoding
package aes_dec_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int BYTE_W      = 8;
  localparam int NUM_BYTES   = 16;
  typedef enum logic [1:0] {WAIT_TABLE, IDLE, LOOKUP, DONE} state_e;
endpackage

// File: rtl/inv_sbox_ram.sv
// inv_sbox_ram: 256x8 inverse S-box table, one write port and one registered read port, no reset
//   clk            rising-edge clock
//   i_we/i_waddr/i_wdata   write strobe, address, data
//   i_re/i_raddr   read strobe and address
//   o_rdata        read data, valid the edge after i_re
module inv_sbox_ram
  import aes_dec_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [BYTE_W-1:0] i_waddr,
  input  logic [BYTE_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [BYTE_W-1:0] i_raddr,
  output logic [BYTE_W-1:0] o_rdata
);
  logic [BYTE_W-1:0] r_mem [256];
  logic [BYTE_W-1:0] r_rdata;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/inv_sub_bytes_engine.sv
// inv_sub_bytes_engine: table-driven AES InvSubBytes over a 128-bit block, one byte per cycle
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_ram_ready                table load complete (honoured only while waiting for the table)
//   i_wr_enable/i_wr_addr/i_wr_data   table write port (honoured only while waiting for the table)
//   i_in_valid/o_in_ready/i_in_state  input block handshake; byte k = bits [8k:8k+7]
//   o_out_valid/i_out_ready/o_out_state  result handshake, same byte order
//   o_busy                     high while a block is being looked up or held for output
module inv_sub_bytes_engine
  import aes_dec_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_ram_ready,
  input  logic                   i_wr_enable,
  input  logic [0:BYTE_W-1]      i_wr_addr,
  input  logic [0:BYTE_W-1]      i_wr_data,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [0:AES_BLOCK_W-1] i_in_state,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [0:AES_BLOCK_W-1] o_out_state,
  output logic                   o_busy
);
  state_e r_state, w_next;
  logic [0:AES_BLOCK_W-1] r_in_state, r_out_state;
  logic [4:0] r_idx;
  logic w_we, w_re;
  logic [BYTE_W-1:0] w_raddr, w_rdata;
  logic [3:0] w_wbyte;
  assign w_we    = (r_state == WAIT_TABLE) && i_wr_enable;
  assign w_re    = (r_state == LOOKUP) && (r_idx < 5'(NUM_BYTES));
  assign w_raddr = r_in_state[{r_idx[3:0], 3'b000} +: BYTE_W];
  // The byte written lags the byte read by one edge; at idx 16 this wraps to byte 15.
  assign w_wbyte = r_idx[3:0] - 4'd1;
  inv_sbox_ram u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (i_wr_addr),
    .i_wdata (i_wr_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= WAIT_TABLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      WAIT_TABLE: w_next = i_ram_ready ? IDLE : WAIT_TABLE;
      IDLE:       w_next = i_in_valid ? LOOKUP : IDLE;
      LOOKUP:     w_next = (r_idx == 5'(NUM_BYTES)) ? DONE : LOOKUP;
      DONE:       w_next = i_out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_state  <= '0;
      r_out_state <= '0;
      r_idx       <= '0;
    end else if (r_state == IDLE && i_in_valid) begin
      r_in_state <= i_in_state;
      r_idx      <= '0;
    end else if (r_state == LOOKUP) begin
      if (r_idx != '0) r_out_state[{w_wbyte, 3'b000} +: BYTE_W] <= w_rdata;
      if (w_re) r_idx <= r_idx + 5'd1;
    end
  end
  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = (r_state == DONE);
  assign o_busy      = (r_state == LOOKUP) || (r_state == DONE);
  assign o_out_state = r_out_state;
endmodule
